acr_dma_copy: RTL and testbench
===============================

# acr_dma_copy

Parametrised AXI copy engine for the accelerator's memory port: accepts one copy command (source, destination, beat count), splits it into INCR bursts that never cross a 4 KB boundary, reads through the AR/R channels into an internal FIFO, and writes out through AW/W/B. It generalises the accelerator's fixed 32-bit-address, 64-bit-data, 16-beat AXI master with parametrised widths, burst length and buffer depth, read/write overlap, and response-error reporting.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width in bits (power of 2, ≥8); beat size B = DATA_W/8 bytes
- BURST_LEN, 16, max beats per burst (1..16, AXI3 len)
- FIFO_DEPTH, 32, data FIFO entries (power of 2, ≥ BURST_LEN)
- acr_clk  in  1  clock; all logic on rising edge
- acr_rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_src, cmd_dst  in  ADDR_W  byte addresses; low log2(B) bits ignored (forced 0)
- cmd_beats  in  16  beats to copy; 0 means a no-op
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky: any rresp/bresp ≠ 0 during the current command
- axi_araddr out ADDR_W; axi_arlen out 4; axi_arvalid out 1; axi_arready in 1
- axi_rdata in DATA_W; axi_rresp in 2; axi_rlast in 1; axi_rvalid in 1; axi_rready out 1
- axi_awaddr out ADDR_W; axi_awlen out 4; axi_awvalid out 1; axi_awready in 1
- axi_wdata out DATA_W; axi_wstrb out DATA_W/8 (all ones); axi_wlast out 1; axi_wvalid out 1; axi_wready in 1
- axi_bresp in 2; axi_bvalid in 1; axi_bready out 1
- Size log2(B), INCR burst, lock/cache/prot = 0 are fixed; the wrapper ties those pins.

## Operation
- Control FSM states IDLE, RUN, FIN. IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch addresses and count, clear err, set busy, go to RUN, or to FIN directly when cmd_beats=0.
- Burst length L = min(BURST_LEN, remaining beats, beats to next 4 KB boundary of that side's address). Read and write sides split independently.
- Read side: at most one AR outstanding. Issue AR only when FIFO free space minus reserved beats ≥ L. Reserve L beats at AR issue. rready=1 whenever a read burst is outstanding; R never stalls. On the last R beat (rlast), the next AR can issue.
- Write side: at most one AW outstanding and one B pending. Issue AW when FIFO occupancy ≥ L. Stream L beats, wlast on beat L. bready=1 while B is pending. The next AW is not issued before the B handshake.
- FIN: entered when the last B handshake of the command completes (or from IDLE for a no-op). Asserts done for one cycle, clears busy, returns to IDLE.
- Error: any rresp≠0 or bresp≠0 sets err. The copy still runs to completion, and err holds until the next command accept.
- Addresses advance by L·B per burst with ADDR_W-bit wrap.

## Timing
- Reset values: cmd_ready=1; busy, done, err, arvalid, rready, awvalid, wvalid, wlast, bready = 0; address and len outputs = 0; FIFO empty.
- Reset mid-transfer: on the next edge, all state and outputs return to reset values and the transfer is abandoned.
- AR/AW outputs are registered. arvalid rises 1 cycle after command accept at the earliest. A valid, once asserted, holds with stable payload until its ready.
- FIFO is first-word-fall-through. wdata is valid in the same cycle wvalid rises. An R beat written at edge n can be presented as a W beat at cycle n+1.
- Read and write sides overlap: AR for burst k+1 may issue while burst k is being written.
- done rises 1 cycle after the final bvalid&bready. A new command is accepted 1 cycle after done.

## Test plan
- cmd_beats=4, src=0x1000, dst=0x2000, always-ready slave -> one AR (0x1000, len 3), one AW (0x2000, len 3), W data equals R data, done pulses once, err=0.
- cmd_beats=40, BURST_LEN=16 -> AR and AW lens 15, 15, 7; addresses step 0x80; exactly 40 W beats; wlast on beats 16, 32, 40.
- src=0x0FF8, dst=0x3000, cmd_beats=4, DATA_W=64 -> reads split into len 0 at 0x0FF8 and len 2 at 0x1000; write is a single AW of len 3.
- bresp=2'b10 on the second of three bursts -> all three bursts still complete, err=1 at done; next command accept clears err to 0.
- wready held low 40 cycles, cmd_beats=64, FIFO_DEPTH=32 -> at most 32 beats buffered, no AR issued without space, no R data lost, output data correct.
- acr_rst pulsed during the 3rd R beat -> next cycle all outputs are at reset values and cmd_ready=1; a fresh command then completes normally.

Source files
------------

// File: rtl/acr_dma_copy.sv
// acr_dma_copy: AXI memory-to-memory copy engine.
// One command (src, dst, beat count) is split into INCR bursts that never
// cross a 4 KB page. Read bursts land in a first-word-fall-through FIFO and
// are streamed back out as write bursts; the two sides run concurrently.
//
// Handshake rule used on every channel: a transfer happens on a rising edge
// where valid and ready are both high; a valid, once raised, stays high with
// a stable payload until that edge.
module acr_dma_copy #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                acr_clk,
   input  logic                acr_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_src,
   input  logic [ADDR_W-1:0]   cmd_dst,
   input  logic [15:0]         cmd_beats,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          dbg_state,
   output logic [ADDR_W-1:0]   axi_araddr,
   output logic [3:0]          axi_arlen,
   output logic                axi_arvalid,
   input  logic                axi_arready,
   input  logic [DATA_W-1:0]   axi_rdata,
   input  logic [1:0]          axi_rresp,
   input  logic                axi_rlast,
   input  logic                axi_rvalid,
   output logic                axi_rready,
   output logic [ADDR_W-1:0]   axi_awaddr,
   output logic [3:0]          axi_awlen,
   output logic                axi_awvalid,
   input  logic                axi_awready,
   output logic [DATA_W-1:0]   axi_wdata,
   output logic [DATA_W/8-1:0] axi_wstrb,
   output logic                axi_wlast,
   output logic                axi_wvalid,
   input  logic                axi_wready,
   input  logic [1:0]          axi_bresp,
   input  logic                axi_bvalid,
   output logic                axi_bready
);

   localparam int BYTES = DATA_W / 8;
   localparam int BSH   = $clog2(BYTES);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [15:0]       rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
   logic              err_q, err_d;
   logic              arvalid_q, arvalid_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [3:0]        arlen_q, arlen_d;
   logic              rd_out_q, rd_out_d;
   logic [CW-1:0]     rsv_q, rsv_d;
   logic              awvalid_q, awvalid_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [3:0]        awlen_q, awlen_d;
   logic              w_act_q, w_act_d;
   logic [4:0]        w_left_q, w_left_d;
   logic              b_pend_q, b_pend_d;
   logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   logic              r_hs, w_hs, b_hs, ar_go, aw_go;
   logic [4:0]        l_rd, l_wr;
   logic [CW-1:0]     free;

   // Beats in the next burst: limited by max length, what is left, and the
   // distance to the next 4 KB page of this side's address.
   function automatic logic [4:0] burst_len(input logic [ADDR_W-1:0] addr,
                                            input logic [15:0] rem);
      logic [12:0] to_bound;
      logic [15:0] l;
      to_bound = (13'h1000 - {1'b0, addr[11:0]}) >> BSH;
      l = 16'(BURST_LEN);
      if (rem < l) l = rem;
      if ({3'b000, to_bound} < l) l = {3'b000, to_bound};
      return l[4:0];
   endfunction

   assign r_hs = axi_rvalid && rd_out_q;
   assign w_hs = w_act_q && axi_wready;
   assign b_hs = axi_bvalid && b_pend_q;
   assign l_rd = burst_len(src_q, rd_rem_q);
   assign l_wr = burst_len(dst_q, wr_rem_q);
   // Space not yet holding data nor promised to an outstanding read burst.
   assign free = CW'(FIFO_DEPTH) - cnt_q - rsv_q;
   assign ar_go = (state_q == ST_RUN) && !rd_out_q && (rd_rem_q != 16'd0) &&
                  (32'(free) >= 32'(l_rd));
   assign aw_go = (state_q == ST_RUN) && !w_act_q && !b_pend_q && !awvalid_q &&
                  (wr_rem_q != 16'd0) && (32'(cnt_q) >= 32'(l_wr));

   // Next-state logic for the control FSM and both channel engines.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rd_rem_d  = rd_rem_q;
      wr_rem_d  = wr_rem_q;
      err_d     = err_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      rd_out_d  = rd_out_q;
      rsv_d     = rsv_q;
      awvalid_d = awvalid_q;
      awaddr_d  = awaddr_q;
      awlen_d   = awlen_q;
      w_act_d   = w_act_q;
      w_left_d  = w_left_q;
      b_pend_d  = b_pend_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;

      if ((r_hs && axi_rresp != 2'b00) || (b_hs && axi_bresp != 2'b00)) err_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               src_d    = cmd_src & ~ADDR_W'(BYTES - 1);
               dst_d    = cmd_dst & ~ADDR_W'(BYTES - 1);
               rd_rem_d = cmd_beats;
               wr_rem_d = cmd_beats;
               err_d    = 1'b0;
               state_d  = (cmd_beats == 16'd0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            // The B for the last write burst ends the command.
            if (b_hs && wr_rem_q == 16'd0) state_d = ST_FIN;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Read side.
      if (arvalid_q && axi_arready) arvalid_d = 1'b0;
      if (ar_go) begin
         arvalid_d = 1'b1;
         araddr_d  = src_q;
         arlen_d   = 4'(l_rd - 5'd1);
         rd_out_d  = 1'b1;
         src_d     = src_q + (ADDR_W'(l_rd) << BSH);
         rd_rem_d  = rd_rem_q - 16'(l_rd);
      end
      if (r_hs && axi_rlast) rd_out_d = 1'b0;
      rsv_d = rsv_q + (ar_go ? CW'(l_rd) : CW'(0)) - CW'(r_hs);

      // Write side.
      if (awvalid_q && axi_awready) awvalid_d = 1'b0;
      if (aw_go) begin
         awvalid_d = 1'b1;
         awaddr_d  = dst_q;
         awlen_d   = 4'(l_wr - 5'd1);
         w_act_d   = 1'b1;
         w_left_d  = l_wr;
         dst_d     = dst_q + (ADDR_W'(l_wr) << BSH);
         wr_rem_d  = wr_rem_q - 16'(l_wr);
      end
      if (w_hs) begin
         w_left_d = w_left_q - 5'd1;
         if (w_left_q == 5'd1) begin
            w_act_d  = 1'b0;
            b_pend_d = 1'b1;
         end
      end
      if (b_hs) b_pend_d = 1'b0;

      // FIFO bookkeeping.
      if (r_hs) wptr_d = wptr_q + PW'(1);
      if (w_hs) rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(r_hs) - CW'(w_hs);
   end

   // State registers with synchronous reset.
   always_ff @(posedge acr_clk) begin
      if (acr_rst) begin
         state_q   <= ST_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         rd_rem_q  <= '0;
         wr_rem_q  <= '0;
         err_q     <= 1'b0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         rd_out_q  <= 1'b0;
         rsv_q     <= '0;
         awvalid_q <= 1'b0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         w_act_q   <= 1'b0;
         w_left_q  <= '0;
         b_pend_q  <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rd_rem_q  <= rd_rem_d;
         wr_rem_q  <= wr_rem_d;
         err_q     <= err_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         rd_out_q  <= rd_out_d;
         rsv_q     <= rsv_d;
         awvalid_q <= awvalid_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         w_act_q   <= w_act_d;
         w_left_q  <= w_left_d;
         b_pend_q  <= b_pend_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge acr_clk) begin
      if (r_hs && !acr_rst) mem[wptr_q] <= axi_rdata;
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q == ST_RUN);
   assign done        = (state_q == ST_FIN);
   assign err         = err_q;
   assign dbg_state   = state_q;
   assign axi_araddr  = araddr_q;
   assign axi_arlen   = arlen_q;
   assign axi_arvalid = arvalid_q;
   assign axi_rready  = rd_out_q;
   assign axi_awaddr  = awaddr_q;
   assign axi_awlen   = awlen_q;
   assign axi_awvalid = awvalid_q;
   assign axi_wdata   = mem[rptr_q];
   assign axi_wstrb   = '1;
   assign axi_wvalid  = w_act_q;
   assign axi_wlast   = w_act_q && (w_left_q == 5'd1);
   assign axi_bready  = b_pend_q;

endmodule

// File: tb/tb_acr_dma_copy.sv
// Bench for acr_dma_copy: directed commands against a behavioural AXI slave.
// Expected bursts and write data are queued when a command is issued and
// consumed as the DUT's AR/AW/W handshakes appear.
module tb_acr_dma_copy;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   logic              acr_clk = 1'b0;
   logic              acr_rst = 1'b1;
   logic              cmd_valid = 1'b0, cmd_ready;
   logic [ADDR_W-1:0] cmd_src = '0, cmd_dst = '0;
   logic [15:0]       cmd_beats = '0;
   logic              busy, done, err;
   logic [1:0]        dbg_state;
   logic [ADDR_W-1:0] axi_araddr, axi_awaddr;
   logic [3:0]        axi_arlen, axi_awlen;
   logic              axi_arvalid, axi_arready = 1'b0;
   logic [DATA_W-1:0] axi_rdata = '0, axi_wdata;
   logic [1:0]        axi_rresp = '0, axi_bresp = '0;
   logic              axi_rlast = 1'b0, axi_rvalid = 1'b0, axi_rready;
   logic              axi_awvalid, axi_awready = 1'b0;
   logic [7:0]        axi_wstrb;
   logic              axi_wlast, axi_wvalid, axi_wready = 1'b0;
   logic              axi_bvalid = 1'b0, axi_bready;

   acr_dma_copy #(.ADDR_W(32), .DATA_W(64), .BURST_LEN(16), .FIFO_DEPTH(32)) dut (
      .acr_clk(acr_clk), .acr_rst(acr_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src),
      .cmd_dst(cmd_dst), .cmd_beats(cmd_beats),
      .busy(busy), .done(done), .err(err), .dbg_state(dbg_state),
      .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
      .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
      .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   // clock / reset
   always #5 acr_clk = ~acr_clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  len;
   } burst_t;

   int checks = 0;
   int errors = 0;

   // scoreboard
   burst_t            exp_ar_q[$];
   burst_t            exp_aw_q[$];
   logic [DATA_W-1:0] exp_q[$];
   int                exp_wl_q[$];

   // slave state
   burst_t      r_q[$];
   burst_t      ebuf;
   logic [31:0] seed = 32'h1234_5678;
   bit          rand_rdy = 1'b0;
   bit          w_hold = 1'b0;
   bit          last_exp;
   int r_beat = 0, r_bidx = 0, r_err_idx = -1, b_idx = 0, b_err_idx = -1;
   int aw_hs_cnt = 0, wl_hs_cnt = 0, b_hs_cnt = 0, w_beat = 0;
   int r_beats = 0, w_beats = 0, buf_cnt = 0, max_buf = 0;

   function automatic logic [63:0] pat(input logic [31:0] a);
      return {a ^ seed, ~a + seed};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // AXI slave: drive on the falling edge, then evaluate what the next rising
   // edge will transfer.
   always @(negedge acr_clk) begin
      if (acr_rst) begin
         r_q.delete();
         r_beat = 0; r_bidx = 0; b_idx = 0; aw_hs_cnt = 0; wl_hs_cnt = 0;
         b_hs_cnt = 0; w_beat = 0; r_beats = 0; w_beats = 0; buf_cnt = 0;
         axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
         axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
         axi_bvalid = 1'b0; axi_bresp = 2'b00;
      end else begin
         axi_arready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         axi_awready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         axi_wready  = !w_hold && (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
         if (r_q.size() != 0 && (!rand_rdy || $urandom_range(0, 4) != 0)) begin
            axi_rvalid = 1'b1;
            axi_rdata  = pat(r_q[0].addr + 32'(r_beat * 8));
            axi_rlast  = (r_beat == int'(r_q[0].len));
            axi_rresp  = (r_bidx == r_err_idx) ? 2'b10 : 2'b00;
         end else begin
            axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
         end
         if (aw_hs_cnt > b_hs_cnt && wl_hs_cnt > b_hs_cnt) begin
            axi_bvalid = 1'b1;
            axi_bresp  = (b_idx == b_err_idx) ? 2'b10 : 2'b00;
         end else begin
            axi_bvalid = 1'b0; axi_bresp = 2'b00;
         end
         #1;
         if (axi_arvalid && axi_arready) begin
            check("ar_pending", 64'(exp_ar_q.size() != 0), 64'(1));
            if (exp_ar_q.size() != 0) begin
               ebuf = exp_ar_q.pop_front();
               check("ar_addr", 64'(axi_araddr), 64'(ebuf.addr));
               check("ar_len", 64'(axi_arlen), 64'(ebuf.len));
            end
            ebuf.addr = axi_araddr; ebuf.len = axi_arlen;
            r_q.push_back(ebuf);
         end
         if (axi_rvalid && axi_rready) begin
            r_beats++; buf_cnt++;
            if (buf_cnt > max_buf) max_buf = buf_cnt;
            if (axi_rlast) begin
               void'(r_q.pop_front()); r_beat = 0; r_bidx++;
            end else r_beat++;
         end
         if (axi_awvalid && axi_awready) begin
            check("aw_pending", 64'(exp_aw_q.size() != 0), 64'(1));
            if (exp_aw_q.size() != 0) begin
               ebuf = exp_aw_q.pop_front();
               check("aw_addr", 64'(axi_awaddr), 64'(ebuf.addr));
               check("aw_len", 64'(axi_awlen), 64'(ebuf.len));
            end
            aw_hs_cnt++;
         end
         if (axi_wvalid && axi_wready) begin
            check("w_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("w_data", axi_wdata, exp_q.pop_front());
            check("w_strb", 64'(axi_wstrb), 64'(8'hFF));
            w_beat++; w_beats++; buf_cnt--;
            last_exp = (exp_wl_q.size() != 0) && (w_beat == exp_wl_q[0]);
            check("w_last", 64'(axi_wlast), 64'(last_exp));
            if (last_exp) begin
               void'(exp_wl_q.pop_front()); w_beat = 0; wl_hs_cnt++;
            end
         end
         if (axi_bvalid && axi_bready) begin
            b_hs_cnt++; b_idx++;
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge acr_clk); #2;
   endtask

   task automatic push_ar(input logic [31:0] a, input logic [3:0] l);
      burst_t b;
      b.addr = a; b.len = l;
      exp_ar_q.push_back(b);
   endtask

   task automatic push_aw(input logic [31:0] a, input logic [3:0] l);
      burst_t b;
      b.addr = a; b.len = l;
      exp_aw_q.push_back(b);
      exp_wl_q.push_back(int'(l) + 1);
   endtask

   task automatic push_data(input logic [31:0] src, input int beats);
      for (int i = 0; i < beats; i++) exp_q.push_back(pat(src + 32'(i * 8)));
   endtask

   task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] beats);
      int n;
      cmd_src = src; cmd_dst = dst; cmd_beats = beats; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin tick(); n++; end
      check("cmd_accept", 64'(cmd_ready), 64'(1));
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 3000) begin tick(); n++; end
      check({tag, "_done"}, 64'(done), 64'(1));
   endtask

   task automatic finish_cmd(input string tag, input logic exp_err);
      check({tag, "_err"}, 64'(err), 64'(exp_err));
      tick();
      check({tag, "_done_pulse"}, 64'(done), 64'(0));
      check({tag, "_err_hold"}, 64'(err), 64'(exp_err));
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_ar_left"}, 64'(exp_ar_q.size()), 64'(0));
      check({tag, "_aw_left"}, 64'(exp_aw_q.size()), 64'(0));
      check({tag, "_w_left"}, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
      check({tag, "_state"}, 64'(dbg_state), 64'(0));
      check({tag, "_flags"}, 64'({busy, done, err}), 64'(0));
      check({tag, "_valids"}, 64'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready}), 64'(0));
      check({tag, "_araddr"}, 64'(axi_araddr), 64'(0));
      check({tag, "_arlen"}, 64'(axi_arlen), 64'(0));
      check({tag, "_awaddr"}, 64'(axi_awaddr), 64'(0));
      check({tag, "_awlen"}, 64'(axi_awlen), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // directed sequence
   initial begin
      int base, n;
      repeat (3) tick();
      check_reset_outputs("rst");
      acr_rst = 1'b0;
      tick();

      // single 4-beat burst, always-ready slave
      seed = 32'hA5A5_0001;
      push_ar(32'h1000, 4'd3); push_aw(32'h2000, 4'd3); push_data(32'h1000, 4);
      base = w_beats;
      send_cmd(32'h1000, 32'h2000, 16'd4);
      check("t1_busy", 64'(busy), 64'(1));
      wait_done("t1");
      check("t1_wbeats", 64'(w_beats - base), 64'(4));
      finish_cmd("t1", 1'b0);

      // zero-beat no-op
      send_cmd(32'h1000, 32'h2000, 16'd0);
      wait_done("t0");
      finish_cmd("t0", 1'b0);

      // 40 beats: 16+16+8, random ready/valid gaps
      rand_rdy = 1'b1; seed = 32'h0BAD_F00D;
      push_ar(32'h4000, 4'd15); push_ar(32'h4080, 4'd15); push_ar(32'h4100, 4'd7);
      push_aw(32'h8000, 4'd15); push_aw(32'h8080, 4'd15); push_aw(32'h8100, 4'd7);
      push_data(32'h4000, 40);
      base = w_beats;
      send_cmd(32'h4000, 32'h8000, 16'd40);
      wait_done("t2");
      check("t2_wbeats", 64'(w_beats - base), 64'(40));
      finish_cmd("t2", 1'b0);

      // read crosses a 4 KB page; rresp error on the second read burst
      seed = 32'h5555_AAAA;
      push_ar(32'h0FF8, 4'd0); push_ar(32'h1000, 4'd2);
      push_aw(32'h3000, 4'd3); push_data(32'h0FF8, 4);
      r_err_idx = r_bidx + 1;
      send_cmd(32'h0FF8, 32'h3000, 16'd4);
      wait_done("t3");
      finish_cmd("t3", 1'b1);
      r_err_idx = -1;

      // bresp error on the second of three bursts; accept clears old err
      seed = 32'h7777_0000;
      push_ar(32'h6000, 4'd15); push_ar(32'h6080, 4'd15); push_ar(32'h6100, 4'd15);
      push_aw(32'hA000, 4'd15); push_aw(32'hA080, 4'd15); push_aw(32'hA100, 4'd15);
      push_data(32'h6000, 48);
      b_err_idx = b_idx + 1;
      send_cmd(32'h6000, 32'hA000, 16'd48);
      check("t4_err_cleared", 64'(err), 64'(0));
      wait_done("t4");
      finish_cmd("t4", 1'b1);
      b_err_idx = -1;

      // write side stalled: FIFO must cap reads at its depth
      rand_rdy = 1'b0; w_hold = 1'b1; seed = 32'hC0DE_0005; max_buf = buf_cnt;
      for (int k = 0; k < 4; k++) push_ar(32'h5000 + 32'(k * 32'h80), 4'd15);
      for (int k = 0; k < 4; k++) push_aw(32'h9000 + 32'(k * 32'h80), 4'd15);
      push_data(32'h5000, 64);
      base = r_beats;
      send_cmd(32'h5000, 32'h9000, 16'd64);
      check("t5_err_cleared", 64'(err), 64'(0));
      repeat (40) tick();
      check("t5_rbeats_stalled", 64'(r_beats - base), 64'(32));
      check("t5_ar_held", 64'(exp_ar_q.size()), 64'(2));
      check("t5_max_buf", 64'(max_buf <= 32), 64'(1));
      w_hold = 1'b0;
      wait_done("t5");
      check("t5_max_buf_end", 64'(max_buf <= 32), 64'(1));
      finish_cmd("t5", 1'b0);

      // reset during the third R beat abandons the transfer
      seed = 32'h0666_0006;
      push_ar(32'h7000, 4'd7); push_aw(32'hB000, 4'd7); push_data(32'h7000, 8);
      base = r_beats;
      send_cmd(32'h7000, 32'hB000, 16'd8);
      n = 0;
      while ((r_beats - base) < 3 && n < 200) begin tick(); n++; end
      check("t6_third_beat", 64'(r_beats - base), 64'(3));
      acr_rst = 1'b1;
      @(posedge acr_clk);
      tick();
      check_reset_outputs("t6");
      acr_rst = 1'b0;
      exp_ar_q.delete(); exp_aw_q.delete(); exp_q.delete(); exp_wl_q.delete();
      tick();

      // fresh command after reset, both sides split at a page boundary
      rand_rdy = 1'b1; seed = 32'h0777_0007;
      push_ar(32'h1FF0, 4'd1); push_ar(32'h2000, 4'd3);
      push_aw(32'h2FE8, 4'd2); push_aw(32'h3000, 4'd2);
      push_data(32'h1FF0, 6);
      base = w_beats;
      send_cmd(32'h1FF0, 32'h2FE8, 16'd6);
      wait_done("t7");
      check("t7_wbeats", 64'(w_beats - base), 64'(6));
      finish_cmd("t7", 1'b0);

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
